// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, registers the fetched word toward decode,
// and resolves B / BR branches locally by redirecting the PC and injecting a NOP.
module if_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instruction_in,
   input  logic [31:0] br_value,
   output logic [31:0] instruction_out,
   output logic [2:0]  br_addr,
   output logic [31:0] pc
);

   localparam logic [6:0]  OP_B     = 7'b1100000;
   localparam logic [6:0]  OP_BR    = 7'b1100010;
   localparam logic [31:0] NOP_WORD = 32'hC800_0000;

   logic [31:0] pc_r;
   logic [31:0] instr_r;
   logic [31:0] next_pc_s;
   logic [31:0] next_instr_s;
   logic [31:0] b_disp_s;
   logic [6:0]  opcode_s;

   assign opcode_s = instruction_in[31:25];
   // 25-bit word offset, sign-extended and scaled to a byte displacement
   assign b_disp_s = {{5{instruction_in[24]}}, instruction_in[24:0], 2'b00};
   assign br_addr  = instruction_in[24:22];

   // Next-PC and next-instruction selection; branches are squashed into a bubble
   always_comb begin
      next_pc_s    = pc_r + 32'd4;
      next_instr_s = instruction_in;
      case (opcode_s)
         OP_B: begin
            next_pc_s    = pc_r + b_disp_s;
            next_instr_s = NOP_WORD;
         end
         OP_BR: begin
            next_pc_s    = br_value;
            next_instr_s = NOP_WORD;
         end
         default: begin
            next_pc_s    = pc_r + 32'd4;
            next_instr_s = instruction_in;
         end
      endcase
   end

   // PC and decode-side pipeline register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r    <= 32'h0000_0000;
         instr_r <= NOP_WORD;
      end else begin
         pc_r    <= next_pc_s;
         instr_r <= next_instr_s;
      end
   end

   assign pc              = pc_r;
   assign instruction_out = instr_r;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized words
// checked against a PC/pipeline reference model built from the branch rules.
module tb_if_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] instruction_in;
   logic [31:0] br_value;
   logic [31:0] instruction_out;
   logic [2:0]  br_addr;
   logic [31:0] pc;

   int n_cmp;
   int n_err;

   logic [31:0] pc_m;
   logic [31:0] iout_m;

   if_stage dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .instruction_in  (instruction_in),
      .br_value        (br_value),
      .instruction_out (instruction_out),
      .br_addr         (br_addr),
      .pc              (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present a word, take one rising edge, and advance the reference model.
   task automatic drive(input logic [31:0] instr, input logic [31:0] brv);
      logic [6:0] op;
      int         off;
      instruction_in = instr;
      br_value       = brv;
      @(posedge clk);
      #1;
      op = instr[31:25];
      if (op == 7'h60) begin
         off    = $signed(instr[24:0]);
         pc_m   = pc_m + 32'(off * 4);
         iout_m = 32'hC800_0000;
      end else if (op == 7'h62) begin
         pc_m   = brv;
         iout_m = 32'hC800_0000;
      end else begin
         pc_m   = pc_m + 32'd4;
         iout_m = instr;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      instruction_in = 32'h0;
      br_value = 32'h0;
      pc_m = 32'h0;
      iout_m = 32'hC800_0000;
      #12;
      n_cmp++;
      if (pc !== 32'h0) begin
         n_err++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0);
      end
      n_cmp++;
      if (instruction_out !== 32'hC800_0000) begin
         n_err++; $display("FAIL reset_iout: got %h want %h", instruction_out, 32'hC800_0000);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_passthrough;
      logic [31:0] words [3];
      logic [31:0] pcs [3];
      words = '{32'hC800_0000, 32'hFFFF_FFFF, 32'h0000_0000};
      pcs   = '{32'd4, 32'd8, 32'd12};
      for (int i = 0; i < 3; i++) begin
         drive(words[i], 32'h0);
         n_cmp++;
         if (instruction_out !== words[i]) begin
            n_err++; $display("FAIL pass_iout[%0d]: got %h want %h", i, instruction_out, words[i]);
         end
         n_cmp++;
         if (pc !== pcs[i] || pc !== pc_m) begin
            n_err++; $display("FAIL pass_pc[%0d]: got %h want %h", i, pc, pcs[i]);
         end
      end
   endtask

   task automatic test_branch_b;
      // pc is now 12; jump back to 8 first via BR so B 5 starts at pc 8
      drive(32'hC400_0000, 32'd8);
      drive(32'hC000_0005, 32'h0);
      n_cmp++;
      if (pc !== 32'd28 || pc !== pc_m) begin
         n_err++; $display("FAIL b_fwd_pc: got %h want %h", pc, 32'd28);
      end
      n_cmp++;
      if (instruction_out !== 32'hC800_0000) begin
         n_err++; $display("FAIL b_fwd_nop: got %h want %h", instruction_out, 32'hC800_0000);
      end
      drive(32'h8000_0001, 32'h0);
      n_cmp++;
      if (pc !== 32'd32) begin
         n_err++; $display("FAIL b_after_pc: got %h want %h", pc, 32'd32);
      end
   endtask

   task automatic test_branch_br;
      instruction_in = 32'hC400_0000;
      br_value = 32'd9;
      #1;
      n_cmp++;
      if (br_addr !== 3'd0) begin
         n_err++; $display("FAIL br_addr0: got %h want %h", br_addr, 3'd0);
      end
      drive(32'hC400_0000, 32'd9);
      n_cmp++;
      if (pc !== 32'd9) begin
         n_err++; $display("FAIL br_pc: got %h want %h", pc, 32'd9);
      end
      n_cmp++;
      if (instruction_out !== 32'hC800_0000) begin
         n_err++; $display("FAIL br_nop: got %h want %h", instruction_out, 32'hC800_0000);
      end
      drive(32'h1100_1100, 32'hDEAD_BEEF);
      n_cmp++;
      if (pc !== 32'd13 || instruction_out !== 32'h1100_1100) begin
         n_err++; $display("FAIL br_after: got pc %h iout %h want %h %h", pc, instruction_out, 32'd13, 32'h1100_1100);
      end
   endtask

   task automatic test_negative;
      drive(32'hC400_0000, 32'h40);
      drive(32'hC1FF_FFFE, 32'h0);
      n_cmp++;
      if (pc !== 32'h38) begin
         n_err++; $display("FAIL b_neg_pc: got %h want %h", pc, 32'h38);
      end
   endtask

   task automatic test_br_addr_max;
      instruction_in = 32'hC5C0_0000;
      br_value = 32'h1234_5678;
      #1;
      n_cmp++;
      if (br_addr !== 3'b111) begin
         n_err++; $display("FAIL br_addr7: got %h want %h", br_addr, 3'b111);
      end
      drive(32'hC5C0_0000, 32'h1234_5678);
      n_cmp++;
      if (pc !== 32'h1234_5678) begin
         n_err++; $display("FAIL br7_pc: got %h want %h", pc, 32'h1234_5678);
      end
   endtask

   task automatic test_wrap_and_loop;
      drive(32'hC400_0000, 32'hFFFF_FFFC);
      drive(32'h0123_4567, 32'h0);
      n_cmp++;
      if (pc !== 32'h0) begin
         n_err++; $display("FAIL wrap_pc: got %h want %h", pc, 32'h0);
      end
      for (int i = 0; i < 3; i++) begin
         drive(32'hC000_0000, 32'h0);
         n_cmp++;
         if (pc !== 32'h0 || instruction_out !== 32'hC800_0000) begin
            n_err++; $display("FAIL self_loop[%0d]: got pc %h iout %h want %h %h", i, pc, instruction_out, 32'h0, 32'hC800_0000);
         end
      end
   endtask

   task automatic test_random;
      logic [31:0] w;
      logic [31:0] brv;
      for (int i = 0; i < 300; i++) begin
         w   = $urandom;
         brv = $urandom;
         case ($urandom_range(0, 3))
            0: w[31:25] = 7'h60;
            1: w[31:25] = 7'h62;
            2: w[31:25] = 7'h64;
            default: w = w;
         endcase
         instruction_in = w;
         br_value = brv;
         #1;
         n_cmp++;
         if (br_addr !== w[24:22]) begin
            n_err++; $display("FAIL rnd_br_addr[%0d]: got %h want %h", i, br_addr, w[24:22]);
         end
         drive(w, brv);
         n_cmp++;
         if (pc !== pc_m || instruction_out !== iout_m) begin
            n_err++; $display("FAIL rnd_state[%0d]: word %h got pc %h iout %h want %h %h", i, w, pc, instruction_out, pc_m, iout_m);
         end
      end
   endtask

   task automatic test_mid_reset;
      drive(32'h0000_1111, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      pc_m = 32'h0;
      iout_m = 32'hC800_0000;
      n_cmp++;
      if (pc !== 32'h0 || instruction_out !== 32'hC800_0000) begin
         n_err++; $display("FAIL mid_reset: got pc %h iout %h want %h %h", pc, instruction_out, 32'h0, 32'hC800_0000);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(32'h2222_3333, 32'h0);
      n_cmp++;
      if (pc !== 32'd4 || instruction_out !== 32'h2222_3333) begin
         n_err++; $display("FAIL post_reset: got pc %h iout %h want %h %h", pc, instruction_out, 32'd4, 32'h2222_3333);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_passthrough();
      test_branch_b();
      test_branch_br();
      test_negative();
      test_br_addr_max();
      test_wrap_and_loop();
      test_random();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
